wb_commit_checker: RTL
======================

// Module: wb_commit_checker
// PURPOSE
//  Synthesizable, parametrised writeback-commit scoreboard for riscv_core bring-up (sim or FPGA).
//  Checks the core's register-file writes, in order, against a programmable list of expected (rd, value) pairs.
//  Ends with a latched PASS, FAIL (mismatch) or TIMEOUT verdict, plus cycle and commit counts.
//  Attaches to the core's writeback port: reg_write, wb_rd_addr, write_data.
// PARAMETERS
//  XLEN     32   data width of wb_data and expected values
//  DEPTH    16   max expected commits; IDXW = $clog2(DEPTH)
//  TIMEOUT  100  RUN cycles allowed before TIMEOUT verdict (>=1)
//  CNTW     16   width of cycle_count / commit_count
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        synchronous reset, active-low
//  cfg_we        in   1        write expected entry cfg_idx <= {cfg_rd, cfg_data}
//  cfg_idx       in   IDXW     expected-table index
//  cfg_rd        in   5        expected destination register
//  cfg_data      in   XLEN     expected write value
//  cfg_count     in   IDXW+1   number of expected commits, sampled on start
//  start         in   1        begin a check run
//  wb_valid      in   1        core register write this cycle
//  wb_rd_addr    in   5        core write destination
//  wb_data       in   XLEN     core write value
//  busy          out  1        1 while in RUN
//  done          out  1        1 in PASS/FAIL/TIMEOUT
//  pass          out  1        1 only in PASS
//  fail_code     out  2        00 none, 01 mismatch, 10 timeout
//  fail_idx      out  IDXW     expected index at failure
//  fail_got_rd   out  5        offending rd (mismatch only)
//  fail_got_data out  XLEN     offending value (mismatch only)
//  cycle_count   out  CNTW     RUN cycles elapsed, saturating
//  commit_count  out  CNTW     matched commits, saturating
// BEHAVIOUR
//  - FSM: IDLE, RUN, PASS, FAIL, TIMEOUT. All outputs are registered.
//  - Reset: state=IDLE; all outputs 0; ptr=0.
//  - Reset: expected table is NOT cleared.
//  - Reset mid-RUN: abort to IDLE with outputs 0.
//  - cfg_we: honoured in IDLE and terminal states; ignored in RUN.
//  - start in IDLE or terminal state:
//    - latch n=min(cfg_count, DEPTH); clear ptr, counters, fail fields.
//    - next state RUN, or PASS if n==0.
//  - start while in RUN is ignored.
//  - RUN, every cycle: cycle_count += 1, saturating at 2^CNTW-1.
//  - RUN, commit = wb_valid && wb_rd_addr!=0. Writes to x0 and cycles with wb_valid=0 are ignored.
//  - Matching commit ({rd,data}==exp[ptr]): ptr++, commit_count++.
//    - If ptr==n-1 -> PASS.
//  - Mismatching commit -> FAIL:
//    - fail_code=01, fail_idx=ptr; capture wb_rd_addr and wb_data.
//  - Timeout: on the cycle where cycle_count==TIMEOUT-1 -> TIMEOUT, fail_code=10, fail_idx=ptr.
//  - Same-cycle priority: mismatch > final match (PASS) > timeout.
//  - Latency: verdict visible the cycle after the deciding edge.
//  - Terminal states hold all outputs until start or reset. Commits are ignored there.
// TESTING
//  - Load x1=5, x2=3, x3=8; n=3; start; drive those commits -> pass=1, done=1, commit_count=3 one cycle after 3rd commit.
//  - Same run with x0 writes and wb_valid=0 bubbles interleaved -> still PASS, commit_count=3.
//  - 2nd commit is x2=4 -> fail_code=01, fail_idx=1, fail_got_rd=2, fail_got_data=4, pass=0.
//  - TIMEOUT=20, no commits -> fail_code=10, done=1, cycle_count=20, fail_idx=0.
//  - Final matching commit lands on the TIMEOUT-1 cycle -> PASS, not TIMEOUT.
//  - rst_n low mid-RUN -> IDLE, outputs 0; start with table retained re-runs to PASS.
//  - In RUN, cfg_we and start are ignored.
//  - cfg_count=0 with start -> PASS the next cycle.

Source files
------------

// File: rtl/wb_commit_checker.sv
// wb_commit_checker: in-order writeback-commit scoreboard with a latched PASS/FAIL/TIMEOUT verdict.
module wb_commit_checker #(
    parameter int XLEN = 32,
    parameter int DEPTH = 16,
    parameter int TIMEOUT = 100,
    parameter int CNTW = 16,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cfg_we_i,
    input  logic [IDXW-1:0] cfg_idx_i,
    input  logic [4:0]      cfg_rd_i,
    input  logic [XLEN-1:0] cfg_data_i,
    input  logic [IDXW:0]   cfg_count_i,
    input  logic            start_i,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [1:0]      fail_code_o,
    output logic [IDXW-1:0] fail_idx_o,
    output logic [4:0]      fail_got_rd_o,
    output logic [XLEN-1:0] fail_got_data_o,
    output logic [CNTW-1:0] cycle_count_o,
    output logic [CNTW-1:0] commit_count_o
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_e;

    state_e          state_q;
    logic [XLEN+4:0] exp_q [DEPTH];
    logic [IDXW-1:0] ptr_q, ptr_d, fail_idx_q;
    logic [IDXW:0]   n_q, n_d;
    logic            busy_q, done_q, pass_q;
    logic [1:0]      fail_code_q;
    logic [4:0]      fail_rd_q;
    logic [XLEN-1:0] fail_data_q;
    logic [CNTW-1:0] cycle_q, cycle_d, commit_q, commit_d;
    logic            commit, hit, last, tmo;

    assign n_d      = cfg_count_i > (IDXW+1)'(DEPTH) ? (IDXW+1)'(DEPTH) : cfg_count_i;
    assign commit   = wb_valid_i && wb_rd_addr_i != 5'd0;
    assign hit      = {wb_rd_addr_i, wb_data_i} == exp_q[ptr_q];
    assign last     = {1'b0, ptr_q} == n_q - 1'b1;
    assign tmo      = cycle_q == CNTW'(TIMEOUT - 1);
    assign ptr_d    = ptr_q + IDXW'(commit && hit);
    assign cycle_d  = cycle_q + CNTW'(cycle_q != '1);
    assign commit_d = commit_q + CNTW'(commit && hit && commit_q != '1);

    // The expected table survives reset so a run can be repeated after aborting.
    always_ff @(posedge clk_i)
        if (cfg_we_i && state_q != S_RUN) exp_q[cfg_idx_i] <= {cfg_rd_i, cfg_data_i};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= 2'b00;
            fail_idx_q  <= '0;
            fail_rd_q   <= '0;
            fail_data_q <= '0;
            cycle_q     <= '0;
            commit_q    <= '0;
        end else if (state_q != S_RUN) begin
            if (start_i) begin
                state_q     <= n_d == '0 ? S_PASS : S_RUN;
                busy_q      <= n_d != '0;
                done_q      <= n_d == '0;
                pass_q      <= n_d == '0;
                n_q         <= n_d;
                ptr_q       <= '0;
                fail_code_q <= 2'b00;
                fail_idx_q  <= '0;
                fail_rd_q   <= '0;
                fail_data_q <= '0;
                cycle_q     <= '0;
                commit_q    <= '0;
            end
        end else begin
            cycle_q  <= cycle_d;
            commit_q <= commit_d;
            ptr_q    <= ptr_d;
            // Mismatch beats a final match, which beats the timeout.
            if (commit && !hit) begin
                state_q     <= S_FAIL;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                fail_code_q <= 2'b01;
                fail_idx_q  <= ptr_q;
                fail_rd_q   <= wb_rd_addr_i;
                fail_data_q <= wb_data_i;
            end else if (commit && last) begin
                state_q <= S_PASS;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
            end else if (tmo) begin
                state_q     <= S_TMO;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                fail_code_q <= 2'b10;
                fail_idx_q  <= ptr_d;
            end
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign fail_code_o     = fail_code_q;
    assign fail_idx_o      = fail_idx_q;
    assign fail_got_rd_o   = fail_rd_q;
    assign fail_got_data_o = fail_data_q;
    assign cycle_count_o   = cycle_q;
    assign commit_count_o  = commit_q;
endmodule
